// File: rtl/game_evt_pkg.sv
// game_evt_pkg: shared state encoding, default source count and collision source indices
// for the hit event scheduler.
package game_evt_pkg;
    typedef enum logic {IDLE, OFFER} state_t;
    localparam int NUM_SRC_DEF      = 4;
    localparam int SRC_SHOT_ALIEN   = 0;
    localparam int SRC_BOMB_PLAYER  = 1;
    localparam int SRC_ALIEN_PLAYER = 2;
    localparam int SRC_SHOT_BORDER  = 3;
endpackage

// File: rtl/hit_event_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker; returns the first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);
    logic [2*N-1:0] rot;

    always_comb begin
        rot = {req, req} >> ptr;
        any = |req;
        idx = '0;
        // scan downwards so the nearest request to ptr is the last assignment
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) idx = W'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/hit_event_scheduler.sv
// hit_event_scheduler: per-frame collision capture with one-at-a-time round-robin dispatch.
// Defining HIT_STATS_EN adds per-source saturating handshake counters read via stat_sel.
module hit_event_scheduler
    import game_evt_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int SRC_W   = $clog2(NUM_SRC),
    parameter int STAT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic [NUM_SRC-1:0] coll_in,
    output logic               evt_valid,
    output logic [SRC_W-1:0]   evt_src,
    input  logic               evt_ready,
    output logic               busy,
    output logic               overrun,
    input  logic               ovr_clr
`ifdef HIT_STATS_EN
    ,
    input  logic [SRC_W-1:0]   stat_sel,
    output logic [STAT_W-1:0]  stat_count
`endif
);
    state_t             state, state_n;
    logic [NUM_SRC-1:0] cap, pend, pend_n, done;
    logic [SRC_W-1:0]   rr_ptr, ptr_n, src_n, pick;
    logic               any, hs, valid_n, ovr_set;

    rr_pick #(.N(NUM_SRC), .W(SRC_W)) u_pick (
        .req (pend),
        .ptr (rr_ptr),
        .any (any),
        .idx (pick)
    );

    always_comb begin
        hs      = state == OFFER && evt_ready;
        done    = hs ? (NUM_SRC'(1) << evt_src) : '0;
        // the event completing this cycle must not re-enter pend nor count as overrun
        pend_n  = (pend & ~done) | (startOfFrame ? cap : '0);
        ovr_set = startOfFrame && |(pend & ~done & cap);
        state_n = state;
        valid_n = evt_valid;
        src_n   = evt_src;
        ptr_n   = rr_ptr;
        if (state == IDLE && any) begin
            state_n = OFFER;
            valid_n = 1'b1;
            src_n   = pick;
        end else if (hs) begin
            state_n = IDLE;
            valid_n = 1'b0;
            ptr_n   = (evt_src == SRC_W'(NUM_SRC - 1)) ? '0 : evt_src + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cap       <= '0;
            pend      <= '0;
            rr_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_src   <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cap       <= startOfFrame ? coll_in : cap | coll_in;
            pend      <= pend_n;
            rr_ptr    <= ptr_n;
            evt_valid <= valid_n;
            evt_src   <= src_n;
            overrun   <= ovr_set | (overrun & ~ovr_clr);
        end
    end

    assign busy = |pend | evt_valid;

`ifdef HIT_STATS_EN
    logic [STAT_W-1:0] cnt [NUM_SRC];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
            stat_count <= '0;
        end else begin
            if (hs && cnt[evt_src] != '1) cnt[evt_src] <= cnt[evt_src] + 1'b1;
            stat_count <= (int'(stat_sel) < NUM_SRC) ? cnt[stat_sel] : '0;
        end
    end
`endif
endmodule

// File: tb/tb_hit_event_scheduler.sv
// tb_hit_event_scheduler: directed and randomized checks of the scheduler against a
// per-cycle behavioural model built from the frame/capture/dispatch rules.
module tb_hit_event_scheduler;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset, sof, ready, clr;
    logic [3:0] coll;
    logic       valid, busy, ovr;
    logic [1:0] src;
`ifdef HIT_STATS_EN
    logic [1:0] sel;
    logic [7:0] scount;
`endif

    always #5 clk = ~clk;

    hit_event_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .coll_in      (coll),
        .evt_valid    (valid),
        .evt_src      (src),
        .evt_ready    (ready),
        .busy         (busy),
        .overrun      (ovr),
        .ovr_clr      (clr)
`ifdef HIT_STATS_EN
        ,
        .stat_sel     (sel),
        .stat_count   (scount)
`endif
    );

    bit m_cap [N];
    bit m_pend [N];
    bit m_valid, m_ovr;
    int m_src, m_rr, m_stat;
    int m_cnt [N];
    int n_cmp, n_err;
    int hs_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_cap[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
        end
        m_valid = 0; m_ovr = 0; m_src = 0; m_rr = 0; m_stat = 0;
    endfunction

    function automatic bit m_any();
        for (int i = 0; i < N; i++) if (m_pend[i]) return 1;
        return 0;
    endfunction

    function automatic void m_step(input bit s, input logic [3:0] c, input bit r, input bit k, input int sl);
        bit hs, set;
        bit np [N];
        int pick;
        hs = m_valid && r;
        pick = -1;
        for (int i = 0; i < N; i++)
            if (pick < 0 && m_pend[(m_rr + i) % N]) pick = (m_rr + i) % N;
        np = m_pend;
        if (hs) np[m_src] = 0;
        m_stat = (sl < N) ? m_cnt[sl] : 0;
        if (hs && m_cnt[m_src] < 255) m_cnt[m_src]++;
        set = 0;
        for (int i = 0; i < N; i++) begin
            if (s) begin
                if (np[i] && m_cap[i]) set = 1;
                np[i] = np[i] | m_cap[i];
                m_cap[i] = c[i];
            end else m_cap[i] = m_cap[i] | c[i];
        end
        m_ovr = set ? 1'b1 : (k ? 1'b0 : m_ovr);
        if (!m_valid && pick >= 0) begin
            m_valid = 1; m_src = pick;
        end else if (hs) begin
            m_valid = 0; m_rr = (m_src + 1) % N;
        end
        m_pend = np;
    endfunction

    task automatic check_all();
        chk("evt_valid", valid, m_valid);
        chk("evt_src", src, m_src);
        chk("busy", busy, m_any() || m_valid);
        chk("overrun", ovr, m_ovr);
`ifdef HIT_STATS_EN
        chk("stat_count", scount, m_stat);
`endif
    endtask

    task automatic cy(input bit s, input logic [3:0] c, input bit r, input bit k = 0);
        bit l_hs;
        int l_src, sl;
        sof = s; coll = c; ready = r; clr = k;
        sl = 0;
`ifdef HIT_STATS_EN
        sl = sel;
`endif
        #1;
        l_hs = valid && ready;
        l_src = src;
        @(posedge clk);
        if (l_hs) hs_log.push_back(l_src);
        if (reset) m_reset();
        else m_step(s, c, r, k, sl);
        #1;
        check_all();
    endtask

    function automatic int count_src(input int v);
        int n = 0;
        foreach (hs_log[i]) if (hs_log[i] == v) n++;
        return n;
    endfunction

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1; sof = 0; coll = 0; ready = 0; clr = 0;
`ifdef HIT_STATS_EN
        sel = 0;
`endif
        m_reset();
        cy(0, 0, 0); cy(0, 0, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovr", ovr, 0);
        reset = 0;

        // single event with latency check
        hs_log.delete();
        repeat (5) cy(0, 4'b0010, 1);
        cy(0, 0, 1);
        cy(1, 0, 1);
        chk("lat_t1_valid", valid, 0);
        cy(0, 0, 1);
        chk("lat_t2_valid", valid, 1);
        chk("lat_t2_src", src, 1);
        repeat (4) cy(0, 0, 1);
        chk("single_count", hs_log.size(), 1);
        chk("single_busy", busy, 0);
        chk("single_ovr", ovr, 0);

        // round robin from rr_ptr = 2
        hs_log.delete();
        cy(0, 4'b1011, 1);
        cy(1, 0, 1);
        repeat (8) cy(0, 0, 1);
        chk("rr_count", hs_log.size(), 3);
        if (hs_log.size() == 3) begin
            chk("rr_first", hs_log[0], 3);
            chk("rr_second", hs_log[1], 0);
            chk("rr_third", hs_log[2], 1);
        end

        // back-pressure
        hs_log.delete();
        cy(0, 4'b0100, 0);
        cy(1, 0, 0);
        repeat (12) cy(0, 0, 0);
        chk("bp_held_valid", valid, 1);
        chk("bp_held_src", src, 2);
        cy(0, 0, 1);
        chk("bp_accept", hs_log.size(), 1);
        repeat (3) cy(0, 0, 1);

        // overrun on re-capture of an unsent event
        hs_log.delete();
        cy(0, 4'b0100, 0);
        cy(1, 0, 0);
        repeat (3) cy(0, 0, 0);
        cy(0, 4'b0100, 0);
        cy(1, 0, 0);
        chk("ovr_set", ovr, 1);
        repeat (6) cy(0, 0, 1);
        chk("ovr_single_delivery", count_src(2), 1);
        cy(0, 0, 1, 1);
        chk("ovr_clear", ovr, 0);

        // collision only in the startOfFrame cycle belongs to the new frame
        hs_log.delete();
        cy(1, 4'b0001, 1);
        repeat (6) cy(0, 0, 1);
        chk("bound_not_old", hs_log.size(), 0);
        cy(1, 0, 1);
        repeat (4) cy(0, 0, 1);
        chk("bound_next", count_src(0), 1);

        // randomized traffic
        repeat (600) begin
`ifdef HIT_STATS_EN
            sel = 2'($urandom_range(0, 3));
`endif
            cy($urandom_range(0, 15) == 0,
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0,
               $urandom_range(0, 2) != 0,
               $urandom_range(0, 30) == 0);
        end
`ifdef HIT_STATS_EN
        sel = 0;
`endif
        repeat (8) cy(0, 0, 1, 1);

        // asynchronous reset in the middle of an offer
        cy(0, 4'b1000, 0);
        cy(1, 0, 0);
        cy(0, 0, 0); cy(0, 0, 0);
        chk("pre_rst_valid", valid, 1);
        #2 reset = 1;
        #1 m_reset();
        chk("async_rst_valid", valid, 0);
        chk("async_rst_busy", busy, 0);
        cy(0, 0, 1); cy(0, 0, 1);
        reset = 0;
        hs_log.delete();
        repeat (10) cy(0, 0, 1);
        chk("post_rst_quiet", hs_log.size(), 0);

`ifdef HIT_STATS_EN
        repeat (400) begin
            cy(1, 4'b0001, 1);
            cy(0, 4'b0001, 1);
        end
        repeat (6) cy(0, 0, 1);
        chk("stat_saturate", scount, 255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
